// File: rtl/br_pht.sv
// Pattern history table: 2-bit saturating counters, 1-cycle lookup with
// write-first bypass, and an init sweep after reset and on flush.
module br_pht #(
   parameter int unsigned       IDX_W    = 6,
   parameter int unsigned       DATA_W   = 2,
   parameter logic [DATA_W-1:0] INIT_VAL = 2'b01
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              rd_req,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_taken,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              rd_acc_c;
   logic              wr_act_c;
   logic [DATA_W-1:0] rd_word_c;

   // Next-state logic for the sweep/run controller
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (flush) begin
               clr_cnt_d = '0;
            end else if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
               clr_cnt_d = '0;
               state_d   = ST_RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + IDX_W'(1);
            end
         end
         ST_RUN: begin
            if (flush) begin
               clr_cnt_d = '0;
               state_d   = ST_CLEAR;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   // Lookup acceptance and write-first bypass selection
   always_comb begin
      rd_acc_c  = rd_req && (state_q == ST_RUN);
      wr_act_c  = wr_en && (state_q == ST_RUN);
      rd_word_c = mem[rd_idx];
      if (wr_act_c && (wr_idx == rd_idx)) begin
         rd_word_c = wr_data;
      end
   end

   // State, sweep counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= INIT_VAL;
         rd_taken  <= INIT_VAL[DATA_W-1];
         rd_ready  <= 1'b0;
         busy      <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rd_valid  <= rd_acc_c;
         rd_ready  <= (state_d == ST_RUN);
         busy      <= (state_d == ST_CLEAR);
         if (rd_acc_c) begin
            rd_data  <= rd_word_c;
            rd_taken <= rd_word_c[DATA_W-1];
         end
      end
   end

   // Counter array: the sweep owns it in CLEAR, update writes in RUN
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem[clr_cnt_q] <= INIT_VAL;
      end else if (wr_act_c) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_br_pht.sv
// Self-checking bench for br_pht: directed test-plan scenarios with literal
// expectations plus randomized traffic against a behavioural table model.
module tb_br_pht;

   localparam int unsigned IDX_W = 6;
   localparam int unsigned DEPTH = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flush = 1'b0;
   logic             rd_req = 1'b0;
   logic [IDX_W-1:0] rd_idx = '0;
   logic             rd_ready;
   logic             rd_valid;
   logic [1:0]       rd_data;
   logic             rd_taken;
   logic             wr_en = 1'b0;
   logic [IDX_W-1:0] wr_idx = '0;
   logic [1:0]       wr_data = '0;
   logic             busy;

   int checks = 0;
   int errors = 0;

   br_pht #(.IDX_W(6), .DATA_W(2), .INIT_VAL(2'b01)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .rd_req   (rd_req),
      .rd_idx   (rd_idx),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_taken (rd_taken),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a sweep is just "cycles left until the table reads INIT"
   logic [1:0] mm [DEPTH];
   int         sweep_left = DEPTH;
   logic       exp_valid = 1'b0;
   logic [1:0] exp_data = 2'b01;
   logic       exp_ready = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         sweep_left = DEPTH;
         exp_valid  = 1'b0;
         exp_data   = 2'b01;
         exp_ready  = 1'b0;
      end else begin
         automatic logic ready = (sweep_left == 0);
         exp_valid = rd_req && ready;
         if (exp_valid) begin
            if (wr_en && wr_idx == rd_idx) exp_data = wr_data;
            else                           exp_data = mm[rd_idx];
         end
         if (flush) begin
            if (ready && wr_en) mm[wr_idx] = wr_data;
            sweep_left = DEPTH;
         end else if (ready) begin
            if (wr_en) mm[wr_idx] = wr_data;
         end else begin
            sweep_left--;
            if (sweep_left == 0)
               for (int i = 0; i < DEPTH; i++) mm[i] = 2'b01;
         end
         exp_ready = (sweep_left == 0);
      end
   end

   // Compare every output against the model on the falling edge
   initial begin
      repeat (2) @(posedge clk);
      forever begin
         @(negedge clk);
         chk("rd_ready", 32'(rd_ready), 32'(exp_ready));
         chk("busy",     32'(busy),     32'(!exp_ready));
         chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
         chk("rd_data",  32'(rd_data),  32'(exp_data));
         chk("rd_taken", 32'(rd_taken), 32'(exp_data[1]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_req = 1'b0;
      wr_en  = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic lookup_lit(input string name, input logic [5:0] idx, input logic [1:0] d);
      rd_req = 1'b1;
      rd_idx = idx;
      step();
      chk({name, "_valid"}, 32'(rd_valid), 32'd1);
      chk({name, "_data"},  32'(rd_data),  32'(d));
      chk({name, "_taken"}, 32'(rd_taken), 32'(d[1]));
   endtask

   initial begin
      // Reset, then initial sweep with rd_req held high
      repeat (3) step();
      reset  = 1'b1;
      rd_req = 1'b1;
      rd_idx = 6'd0;
      repeat (63) begin
         step();
         chk("sweep_valid", 32'(rd_valid), 32'd0);
      end
      chk("sweep_busy_63", 32'(busy), 32'd1);
      chk("sweep_ready_63", 32'(rd_ready), 32'd0);
      step();
      chk("sweep_busy_64", 32'(busy), 32'd0);
      chk("sweep_ready_64", 32'(rd_ready), 32'd1);
      chk("sweep_valid_64", 32'(rd_valid), 32'd0);
      lookup_lit("init0", 6'd0, 2'b01);
      lookup_lit("init17", 6'd17, 2'b01);
      lookup_lit("init63", 6'd63, 2'b01);
      idle();

      // Write then read
      wr_en = 1'b1; wr_idx = 6'd5; wr_data = 2'b11;
      step();
      wr_en = 1'b0;
      lookup_lit("wr5", 6'd5, 2'b11);
      lookup_lit("rd6", 6'd6, 2'b01);
      idle();

      // Same-cycle collision bypass
      wr_en = 1'b1; wr_idx = 6'd9; wr_data = 2'b10;
      lookup_lit("byp9", 6'd9, 2'b10);
      wr_en = 1'b0;
      lookup_lit("after9", 6'd9, 2'b10);
      idle();

      // Flush clears, write during sweep dropped
      wr_en = 1'b1; wr_idx = 6'd3; wr_data = 2'b11;
      step();
      wr_en = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; wr_en = 1'b1; wr_idx = 6'd3; wr_data = 2'b00;
      step();
      chk("flush_busy", 32'(busy), 32'd1);
      wr_en = 1'b0;
      repeat (62) step();
      chk("flush_busy_end", 32'(busy), 32'd1);
      step();
      chk("flush_done", 32'(busy), 32'd0);
      lookup_lit("flush3", 6'd3, 2'b01);
      idle();

      // Reset mid-sweep
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (30) step();
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(rd_ready), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      step();
      reset = 1'b1;
      repeat (63) step();
      chk("rst_sweep_ready", 32'(rd_ready), 32'd0);
      step();
      chk("rst_sweep_done", 32'(rd_ready), 32'd1);

      // Boundary indices, back-to-back
      wr_en = 1'b1; wr_idx = 6'd63; wr_data = 2'b10;
      step();
      wr_idx = 6'd0; wr_data = 2'b11;
      step();
      wr_en = 1'b0;
      lookup_lit("b2b63", 6'd63, 2'b10);
      lookup_lit("b2b0", 6'd0, 2'b11);
      lookup_lit("b2b1", 6'd1, 2'b01);
      idle();
      step();
      chk("b2b_end_valid", 32'(rd_valid), 32'd0);
      chk("b2b_hold_data", 32'(rd_data), 32'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rd_req  = ($urandom_range(0, 3) != 0);
         rd_idx  = 6'($urandom_range(0, 63));
         wr_en   = ($urandom_range(0, 1) != 0);
         wr_idx  = ($urandom_range(0, 3) == 0) ? rd_idx : 6'($urandom_range(0, 63));
         wr_data = 2'($urandom_range(0, 3));
         flush   = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
         end else begin
            step();
         end
      end
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
